sseg2hex_capture: RTL
=====================

SSEG2HEX_CAPTURE -- requirements
Module: sseg2hex_capture

Interface
REQ-001 Parameter STABLE_CYC, default 4: consecutive cycles a digit-select/segment pair SHALL hold before capture; legal range 1..255.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 An  input  4  digit anodes, active-low; exactly one bit 0 selects a digit; An[0] is the least significant digit.
REQ-005 Sseg  input  7  segments, active-low, bit6=a .. bit0=g.
REQ-006 Value  output  16  last good frame; An[k] digit occupies Value[4k+3:4k].
REQ-007 Valid  output  1  one-cycle pulse when Value updates.
REQ-008 FrameErr  output  1  one-cycle pulse when a frame completes with one or more undecodable digits.
REQ-009 Seen  output  4  digits captured in the current frame.

Function
REQ-010 Decode table SHALL be: 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9, 0001000->A, 1100000->B, 0110001->C, 1000010->D, 0110000->E, 0111000->F; every other pattern, including 1111111, is invalid.
REQ-011 An and Sseg SHALL be registered once on input; all later timing counts from the registered pair.
REQ-012 FSM states SHALL be IDLE, SETTLE and HELD.
- IDLE: registered An is not one-hot-low.
- SETTLE: counting stability.
- HELD: digit captured, waiting for the pair to change.
REQ-013 IDLE->SETTLE SHALL occur when registered An is one-hot-low; the stability counter loads 1.
REQ-014 In SETTLE, the counter SHALL increment while the pair is unchanged. Any change in the pair SHALL reload the counter to 1 if An is still one-hot-low, else go to IDLE.
REQ-015 Capture SHALL occur on the edge where the counter reaches STABLE_CYC; that edge also moves the FSM to HELD.
- A capture writes the decoded nibble into the digit slot and sets Seen[k].
- An invalid pattern writes the slot as 0 and sets the frame-bad flag.
REQ-016 HELD SHALL perform no further capture. A pair change SHALL go to SETTLE (counter=1) or to IDLE by the same rule as REQ-014.
REQ-017 Re-capture of an already-seen digit before frame completion SHALL overwrite its slot. Seen is unchanged; frame-bad accumulates by OR.
REQ-018 On the edge after Seen becomes 4'b1111, the frame SHALL complete:
- If frame-bad is clear: load Value from the slots and pulse Valid.
- If frame-bad is set: pulse FrameErr and leave Value unchanged.
- In both cases: clear Seen and frame-bad.
REQ-019 If a capture coincides with the completion edge, completion SHALL use the slots as they were before that capture. The new capture SHALL seed the next frame.
REQ-020 The counter SHALL saturate at STABLE_CYC; it never wraps.
REQ-021 With STABLE_CYC=1, capture SHALL occur on the first edge the registered pair is one-hot-low and differs from the previous registered pair.
REQ-022 Valid and FrameErr SHALL never assert in the same cycle.

Reset
REQ-023 With rst_n low, the block SHALL hold: Value=16'h0000, Valid=0, FrameErr=0, Seen=0, FSM=IDLE, counter=0, slots=0, input registers An=4'hF and Sseg=7'h7F.
REQ-024 Assertion of rst_n mid-frame or mid-settle SHALL discard all partial state; no Valid or FrameErr pulse SHALL result.
REQ-025 After rst_n deasserts, the first capture SHALL require a full STABLE_CYC dwell.

Verification
REQ-026 Scan An=1110,1101,1011,0111 carrying patterns for 4,3,2,1, dwell 6 cycles each, STABLE_CYC=4 -> one Valid pulse, Value=16'h1234, FrameErr never asserted.
REQ-027 Same scan with digit 2 as 1111111 -> FrameErr pulse, no Valid, Value holds its previous value; a following clean frame ABCD -> Valid, Value=16'hABCD.
REQ-028 Dwell of 3 cycles per digit with STABLE_CYC=4 -> Seen stays 0, no pulses; An=1100 (two digits selected) held 10 cycles -> FSM stays IDLE, no capture.
REQ-029 rst_n pulsed low after 3 of 4 digits captured -> Seen=0 immediately, Value=0, no pulse; a full scan afterwards -> single Valid.
REQ-030 Digit 0 shown as 5 and then as 9 (two dwells) before the other digits, rest 0,0,0 -> Value=16'h0009.
REQ-031 STABLE_CYC=1 with the digit changing every cycle -> each digit captured, Valid occurs 1 cycle after the fourth capture.

Source files
------------

// File: rtl/sseg2hex_capture.sv
// Recovers a 4-digit hex value from a multiplexed active-low 7-segment drive.
// Each digit must dwell STABLE_CYC cycles before capture; a full frame of four digits updates Value.
module sseg2hex_capture #(
  parameter int STABLE_CYC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  An,
  input  logic [6:0]  Sseg,
  output logic [15:0] Value,
  output logic        Valid,
  output logic        FrameErr,
  output logic [3:0]  Seen
);
  // state  | meaning
  // IDLE   | registered An not one-hot-low
  // SETTLE | counting stability of the registered pair
  // HELD   | digit captured, waiting for the pair to change
  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

  localparam logic [7:0] STAB = 8'(STABLE_CYC);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  an_q, an_p_q;
  logic [6:0]  sseg_q, sseg_p_q;
  logic [15:0] slots_q, slots_d;
  logic [15:0] value_q, value_d;
  logic [3:0]  seen_q, seen_d;
  logic        bad_q, bad_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;

  logic        one_hot, chg, cap, complete, dec_ok;
  logic [3:0]  dec_nib, sel;

  always_comb begin
    dec_ok  = 1'b1;
    dec_nib = 4'h0;
    case (sseg_q)
      7'b0000001: dec_nib = 4'h0;
      7'b1001111: dec_nib = 4'h1;
      7'b0010010: dec_nib = 4'h2;
      7'b0000110: dec_nib = 4'h3;
      7'b1001100: dec_nib = 4'h4;
      7'b0100100: dec_nib = 4'h5;
      7'b0100000: dec_nib = 4'h6;
      7'b0001111: dec_nib = 4'h7;
      7'b0000000: dec_nib = 4'h8;
      7'b0000100: dec_nib = 4'h9;
      7'b0001000: dec_nib = 4'hA;
      7'b1100000: dec_nib = 4'hB;
      7'b0110001: dec_nib = 4'hC;
      7'b1000010: dec_nib = 4'hD;
      7'b0110000: dec_nib = 4'hE;
      7'b0111000: dec_nib = 4'hF;
      default:    dec_ok  = 1'b0;
    endcase
  end

  always_comb begin
    one_hot = 1'b0;
    case (an_q)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: one_hot = 1'b1;
      default:                            one_hot = 1'b0;
    endcase
    sel = ~an_q;
    chg = (an_q != an_p_q) || (sseg_q != sseg_p_q);

    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (one_hot) begin
          state_d = SETTLE;
          cnt_d   = 8'd1;
        end
      end
      SETTLE, HELD: begin
        if (chg) begin
          if (one_hot) begin
            state_d = SETTLE;
            cnt_d   = 8'd1;
          end else begin
            state_d = IDLE;
            cnt_d   = 8'd0;
          end
        end else if (state_q == SETTLE && cnt_q < STAB) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase

    cap = 1'b0;
    if (state_d == SETTLE && cnt_d == STAB) begin
      cap     = 1'b1;
      state_d = HELD;
    end

    // Completion reads the pre-capture slots; a coinciding capture seeds the next frame.
    complete = (seen_q == 4'hF);
    value_d  = (complete && !bad_q) ? slots_q : value_q;
    valid_d  = complete && !bad_q;
    ferr_d   = complete && bad_q;
    seen_d   = complete ? 4'h0 : seen_q;
    bad_d    = complete ? 1'b0 : bad_q;
    slots_d  = slots_q;
    if (cap) begin
      for (int k = 0; k < 4; k++) begin
        if (sel[k]) slots_d[4*k +: 4] = dec_ok ? dec_nib : 4'h0;
      end
      seen_d = seen_d | sel;
      bad_d  = bad_d | !dec_ok;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      an_q     <= 4'hF;
      an_p_q   <= 4'hF;
      sseg_q   <= 7'h7F;
      sseg_p_q <= 7'h7F;
      slots_q  <= 16'h0000;
      value_q  <= 16'h0000;
      seen_q   <= 4'h0;
      bad_q    <= 1'b0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      an_q     <= An;
      an_p_q   <= an_q;
      sseg_q   <= Sseg;
      sseg_p_q <= sseg_q;
      slots_q  <= slots_d;
      value_q  <= value_d;
      seen_q   <= seen_d;
      bad_q    <= bad_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
    end
  end

  assign Value    = value_q;
  assign Valid    = valid_q;
  assign FrameErr = ferr_q;
  assign Seen     = seen_q;
endmodule
